// File: rtl/external_output_scan_if.sv
// Bus bundle for external_output_scan: push-side controls from the datapath
// and the registered 7-segment/select drive back to the board.
interface external_output_scan_if #(
    parameter int DATA_W = 16,
    parameter int SLOTS  = 8,
    parameter int BANKS  = 2
) ();
    localparam int NIB    = DATA_W / 4;
    localparam int DEPTH  = SLOTS * BANKS;
    localparam int SEG_W  = 8 * NIB * BANKS;
    localparam int FILL_W = $clog2(DEPTH + 1);

    logic              out_en;
    logic              push_en;
    logic              clear;
    logic              blank_invalid;
    logic [DATA_W-1:0] din;
    logic [SEG_W-1:0]  seg;
    logic [SLOTS-1:0]  select;
    logic [FILL_W-1:0] fill_count;

    modport master (
        output out_en, push_en, clear, blank_invalid, din,
        input  seg, select, fill_count
    );

    modport slave (
        input  out_en, push_en, clear, blank_invalid, din,
        output seg, select, fill_count
    );
endinterface

// File: rtl/external_output_scan.sv
// Shift history of SLOTS*BANKS words, scanned onto SLOTS one-hot select lines
// with BANKS 7-segment words driven per slot.
module external_output_scan #(
    parameter int DATA_W  = 16,
    parameter int SLOTS   = 8,
    parameter int BANKS   = 2,
    parameter int ON_CYC  = 2,
    parameter int OFF_CYC = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    external_output_scan_if.slave bus
);
    localparam int NIB        = DATA_W / 4;
    localparam int DEPTH      = SLOTS * BANKS;
    localparam int WORD_SEG_W = 8 * NIB;
    localparam int SEG_W      = WORD_SEG_W * BANKS;
    localparam int FILL_W     = $clog2(DEPTH + 1);
    localparam int SLOT_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_MAX    = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    function automatic logic [7:0] digit_seg(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0:    s = 8'hFC;
            4'h1:    s = 8'h60;
            4'h2:    s = 8'hDA;
            4'h3:    s = 8'hF2;
            4'h4:    s = 8'h66;
            4'h5:    s = 8'hB6;
            4'h6:    s = 8'hBE;
            4'h7:    s = 8'hE0;
            4'h8:    s = 8'hFE;
            4'h9:    s = 8'hF6;
            4'hA:    s = 8'hEE;
            4'hB:    s = 8'h3E;
            4'hC:    s = 8'h1A;
            4'hD:    s = 8'h7A;
            4'hE:    s = 8'h9E;
            4'hF:    s = 8'h8E;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Most-significant nibble lands in the top byte; the last digit carries the dp.
    function automatic logic [WORD_SEG_W-1:0] word_seg(input logic [DATA_W-1:0] w,
                                                       input logic vld,
                                                       input logic blank);
        logic [WORD_SEG_W-1:0] r;
        logic [DATA_W-1:0]     v;
        v = vld ? w : '0;
        r = '0;
        for (int n = 0; n < NIB; n++) begin
            r[n*8 +: 8] = digit_seg(v[n*4 +: 4]);
        end
        r[0] = 1'b1;
        return (!vld && blank) ? '0 : r;
    endfunction

    logic [DATA_W-1:0] entry_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;
    logic [FILL_W-1:0] fill_r;
    state_t            state_r;
    logic [SLOT_W-1:0] slot_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [SEG_W-1:0]  seg_r;
    logic [SLOTS-1:0]  select_r;

    logic              push_s;
    logic [SLOT_W-1:0] next_slot_s;
    logic [SEG_W-1:0]  seg_next_s;
    logic [SLOTS-1:0]  sel_onehot_s;
    logic [IDX_W-1:0]  idx_s;

    assign push_s = bus.out_en & bus.push_en & ~bus.clear;

    // Next slot index with wrap after the last slot.
    always_comb begin
        next_slot_s = slot_r + SLOT_W'(1);
        if (slot_r == SLOT_W'(SLOTS - 1)) begin
            next_slot_s = '0;
        end else begin
            next_slot_s = slot_r + SLOT_W'(1);
        end
    end

    // Decode of the current slot's entries, bank 0 in the top word.
    always_comb begin
        seg_next_s = '0;
        idx_s      = '0;
        for (int b = 0; b < BANKS; b++) begin
            idx_s = IDX_W'(int'(slot_r) + b * SLOTS);
            seg_next_s[SEG_W-1-b*WORD_SEG_W -: WORD_SEG_W] =
                word_seg(entry_r[idx_s], valid_r[idx_s], bus.blank_invalid);
        end
    end

    // Slot 0 drives the most-significant select line.
    always_comb begin
        sel_onehot_s = '0;
        for (int i = 0; i < SLOTS; i++) begin
            sel_onehot_s[i] = (slot_r == SLOT_W'(SLOTS - 1 - i));
        end
    end

    // History shift register with clear and saturating fill counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) entry_r[i] <= '0;
            valid_r <= '0;
            fill_r  <= '0;
        end else if (bus.clear) begin
            for (int i = 0; i < DEPTH; i++) entry_r[i] <= '0;
            valid_r <= '0;
            fill_r  <= '0;
        end else if (push_s) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                entry_r[i] <= entry_r[i-1];
                valid_r[i] <= valid_r[i-1];
            end
            entry_r[0] <= bus.din;
            valid_r[0] <= 1'b1;
            if (fill_r != FILL_W'(DEPTH)) begin
                fill_r <= fill_r + FILL_W'(1);
            end
        end
    end

    // Scan FSM: LOAD captures seg, ON drives select, OFF blanks before next slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_LOAD;
            slot_r   <= '0;
            cnt_r    <= '0;
            seg_r    <= '0;
            select_r <= '0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    seg_r    <= seg_next_s;
                    select_r <= '0;
                    cnt_r    <= '0;
                    state_r  <= ST_ON;
                end
                ST_ON: begin
                    select_r <= sel_onehot_s;
                    if (cnt_r == CNT_W'(ON_CYC - 1)) begin
                        cnt_r <= '0;
                        if (OFF_CYC == 0) begin
                            state_r <= ST_LOAD;
                            slot_r  <= next_slot_s;
                        end else begin
                            state_r <= ST_OFF;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_OFF: begin
                    select_r <= '0;
                    if (cnt_r == CNT_W'(OFF_CYC - 1)) begin
                        cnt_r   <= '0;
                        state_r <= ST_LOAD;
                        slot_r  <= next_slot_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r  <= ST_LOAD;
                    slot_r   <= '0;
                    cnt_r    <= '0;
                    select_r <= '0;
                end
            endcase
        end
    end

    assign bus.seg        = seg_r;
    assign bus.select     = select_r;
    assign bus.fill_count = fill_r;
endmodule

// File: tb/tb_external_output_scan.sv
// Directed bench for external_output_scan: default instance plus a small
// non-default instance sharing clock and reset.
module tb_external_output_scan;
    logic clk;
    logic rst_n;
    int   edge_n;
    int   total;
    int   bad;

    external_output_scan_if #(.DATA_W(16), .SLOTS(8), .BANKS(2)) bus_a ();
    external_output_scan_if #(.DATA_W(8),  .SLOTS(4), .BANKS(1)) bus_b ();

    external_output_scan #(.DATA_W(16), .SLOTS(8), .BANKS(2), .ON_CYC(2), .OFF_CYC(1))
        u_dut (.clock(clk), .reset(rst_n), .bus(bus_a));

    external_output_scan #(.DATA_W(8), .SLOTS(4), .BANKS(1), .ON_CYC(3), .OFF_CYC(2))
        u_small (.clock(clk), .reset(rst_n), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int r);
        tick();
        while (edge_n % 32 != r) tick();
    endtask

    initial begin
        logic [7:0] exp_sel;
        int ph;
        int s;
        total  = 0;
        bad    = 0;
        edge_n = -1;
        rst_n  = 1'b0;
        bus_a.out_en = 1'b0; bus_a.push_en = 1'b0; bus_a.clear = 1'b0;
        bus_a.blank_invalid = 1'b0; bus_a.din = 16'h0000;
        bus_b.out_en = 1'b0; bus_b.push_en = 1'b0; bus_b.clear = 1'b0;
        bus_b.blank_invalid = 1'b0; bus_b.din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_seg",    64'(bus_a.seg),        64'h0);
        check_eq("rst_select", 64'(bus_a.select),     64'h0);
        check_eq("rst_fill",   64'(bus_a.fill_count), 64'h0);
        #3;
        rst_n = 1'b1;

        // Free run, no pushes, legacy zero display
        for (int e = 0; e < 36; e++) begin
            tick();
            ph = edge_n % 4;
            s  = (edge_n / 4) % 8;
            exp_sel = (ph == 1 || ph == 2) ? (8'h80 >> s) : 8'h00;
            check_eq($sformatf("run_sel_e%0d", edge_n), 64'(bus_a.select), 64'(exp_sel));
            if (ph == 0) begin
                check_eq($sformatf("run_seg_e%0d", edge_n), bus_a.seg, 64'hFCFCFCFD_FCFCFCFD);
            end
        end
        check_eq("run_fill", 64'(bus_a.fill_count), 64'h0);

        // Single push with blanking of invalid entries
        bus_a.blank_invalid = 1'b1;
        bus_a.din = 16'h1234; bus_a.out_en = 1'b1; bus_a.push_en = 1'b1;
        bus_b.din = 8'h3C;    bus_b.out_en = 1'b1; bus_b.push_en = 1'b1;
        tick();
        bus_a.push_en = 1'b0; bus_b.push_en = 1'b0;
        check_eq("one_fill", 64'(bus_a.fill_count), 64'd1);
        run_to(0);
        check_eq("one_seg_s0", bus_a.seg, 64'h60DAF267_00000000);
        run_to(4);
        check_eq("one_seg_s1", bus_a.seg, 64'h0);

        // Clear, then 17 back-to-back pushes
        bus_a.clear = 1'b1;
        tick();
        bus_a.clear = 1'b0;
        bus_a.push_en = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            bus_a.din = 16'(i);
            tick();
        end
        bus_a.push_en = 1'b0;
        check_eq("sat_fill", 64'(bus_a.fill_count), 64'd16);
        run_to(0);
        check_eq("sat_seg_s0", bus_a.seg, 64'hFCFC6061_FCFCFCF7);
        run_to(28);
        check_eq("sat_seg_s7", bus_a.seg, 64'hFCFCFCEF_FCFCFCDB);

        // Push on the LOAD edge of slot 0
        run_to(31);
        bus_a.din = 16'hABCD; bus_a.push_en = 1'b1;
        tick();
        bus_a.push_en = 1'b0;
        check_eq("edge_seg_old", bus_a.seg, 64'hFCFC6061_FCFCFCF7);
        check_eq("edge_fill",    64'(bus_a.fill_count), 64'd16);
        tick();
        check_eq("edge_seg_hold", bus_a.seg, 64'hFCFC6061_FCFCFCF7);
        run_to(0);
        check_eq("edge_seg_new", bus_a.seg, 64'hEE3E1A7B_FCFCFCEF);

        // Clear beats a simultaneous push
        bus_a.clear = 1'b1; bus_a.push_en = 1'b1; bus_a.din = 16'h5555;
        tick();
        bus_a.clear = 1'b0; bus_a.push_en = 1'b0;
        check_eq("clr_fill", 64'(bus_a.fill_count), 64'h0);
        check_eq("clr_sel",  64'(bus_a.select),     64'h80);
        run_to(4);
        check_eq("clr_seg_s1", bus_a.seg, 64'h0);
        tick();
        check_eq("clr_sel_s1", 64'(bus_a.select), 64'h40);
        run_to(0);
        check_eq("clr_seg_s0", bus_a.seg, 64'h0);

        // Reset mid-ON of slot 2
        run_to(9);
        check_eq("pre_sel",        64'(bus_a.select),     64'h20);
        check_eq("pre_small_fill", 64'(bus_b.fill_count), 64'd1);
        #2;
        rst_n = 1'b0;
        bus_a.blank_invalid = 1'b0;
        #1;
        check_eq("mid_seg",        bus_a.seg,             64'h0);
        check_eq("mid_select",     64'(bus_a.select),     64'h0);
        check_eq("mid_fill",       64'(bus_a.fill_count), 64'h0);
        check_eq("mid_small_seg",  64'(bus_b.seg),        64'h0);
        check_eq("mid_small_sel",  64'(bus_b.select),     64'h0);
        check_eq("mid_small_fill", 64'(bus_b.fill_count), 64'h0);
        #1;
        rst_n  = 1'b1;
        edge_n = -1;
        tick();
        check_eq("rel_seg",       bus_a.seg,         64'hFCFCFCFD_FCFCFCFD);
        check_eq("rel_small_seg", 64'(bus_b.seg),    64'hFCFD);
        check_eq("rel_small_e0",  64'(bus_b.select), 64'h0);
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_sel = (e <= 3) ? 8'h08 : ((e == 7) ? 8'h04 : 8'h00);
            check_eq($sformatf("rel_small_e%0d", e), 64'(bus_b.select), 64'(exp_sel));
            if (e == 1) begin
                check_eq("rel_sel_e1", 64'(bus_a.select), 64'h80);
            end
        end
        check_eq("rel_small_seg6", 64'(bus_b.seg), 64'hFCFD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
